// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the transposed-conv control blocks: sequencer state
// encoding and default FIFO geometry.
package conv_ctrl_pkg;

  localparam int ADD_WIDTH_DEF = 3;
  localparam int FIFO_SIZE_DEF = 8;
  localparam int PASS_W_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FILL,
    ST_GAP,
    ST_ACC,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/psum_fifo_seq.sv
// Partial-sum FIFO sequencer: fill pass, read-add-write accumulate passes,
// then a drain pass that streams the finished row out of the FIFO.
module psum_fifo_seq
  import conv_ctrl_pkg::*;
#(
  parameter int ADD_WIDTH = ADD_WIDTH_DEF,
  parameter int FIFO_SIZE = FIFO_SIZE_DEF,  // must equal 2**ADD_WIDTH (pointer wrap)
  parameter int PASS_W    = PASS_W_DEF
) (
  input  logic                 clk1,
  input  logic                 rd_clr,
  input  logic                 start,
  input  logic [PASS_W-1:0]    num_pass,
  input  logic [ADD_WIDTH:0]   row_len,
  input  logic                 in_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 fifo_wr_en,
  output logic                 fifo_rd_en,
  output logic                 fifo_wr_inc,
  output logic                 fifo_rd_inc,
  output logic                 fifo_re_buffer,
  output logic                 fifo_wr_clr,
  output logic                 fifo_ptr_rd_clr,
  output logic                 out_valid,
  output logic [PASS_W-1:0]    pass_idx,
  output logic [ADD_WIDTH:0]   beat_idx
);

  localparam logic [ADD_WIDTH:0] ROW_MAX = (ADD_WIDTH+1)'(FIFO_SIZE);

  state_t               state_q, state_d;
  logic [PASS_W-1:0]    num_pass_q, num_pass_d;
  logic [PASS_W-1:0]    pass_q, pass_d;
  logic [ADD_WIDTH:0]   row_len_q, row_len_d;
  logic [ADD_WIDTH:0]   beat_q, beat_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 out_valid_q, out_valid_d;
  logic                 cfg_ok;
  logic [ADD_WIDTH:0]   beat_inc;
  logic [PASS_W-1:0]    pass_inc;

  assign cfg_ok   = (num_pass != '0) && (row_len != '0) && (row_len <= ROW_MAX);
  assign beat_inc = beat_q + 1'b1;
  assign pass_inc = pass_q + 1'b1;

  always_ff @(posedge clk1 or posedge rd_clr) begin
    if (rd_clr) begin
      state_q     <= ST_IDLE;
      num_pass_q  <= '0;
      pass_q      <= '0;
      row_len_q   <= '0;
      beat_q      <= '0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_pass_q  <= num_pass_d;
      pass_q      <= pass_d;
      row_len_q   <= row_len_d;
      beat_q      <= beat_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    num_pass_d      = num_pass_q;
    pass_d          = pass_q;
    row_len_d       = row_len_q;
    beat_d          = beat_q;
    cfg_err_d       = 1'b0;
    out_valid_d     = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    fifo_wr_en      = 1'b0;
    fifo_rd_en      = 1'b0;
    fifo_re_buffer  = 1'b0;
    fifo_wr_clr     = 1'b0;
    fifo_ptr_rd_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (cfg_ok) begin
            num_pass_d = num_pass;
            row_len_d  = row_len;
            pass_d     = '0;
            beat_d     = '0;
            state_d    = ST_CLR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_CLR: begin
        fifo_wr_clr     = 1'b1;
        fifo_ptr_rd_clr = 1'b1;
        state_d         = ST_FILL;
      end
      ST_FILL: begin
        fifo_wr_en = in_valid;
        if (in_valid) begin
          beat_d = beat_inc;
          if (beat_inc == row_len_q) state_d = ST_GAP;
        end
      end
      // Both pointers rewind here while the last registered write retires.
      ST_GAP: begin
        fifo_wr_clr     = 1'b1;
        fifo_ptr_rd_clr = 1'b1;
        beat_d          = '0;
        if (pass_inc < num_pass_q) begin
          pass_d  = pass_inc;
          state_d = ST_ACC;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ACC: begin
        fifo_rd_en     = in_valid;
        fifo_wr_en     = in_valid;
        fifo_re_buffer = in_valid;
        if (in_valid) begin
          beat_d = beat_inc;
          if (beat_inc == row_len_q) state_d = ST_GAP;
        end
      end
      ST_DRAIN: begin
        fifo_rd_en  = 1'b1;
        out_valid_d = 1'b1;
        beat_d      = beat_inc;
        if (beat_inc == row_len_q) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fifo_wr_inc = fifo_wr_en;
  assign fifo_rd_inc = fifo_rd_en;
  assign cfg_err     = cfg_err_q;
  assign out_valid   = out_valid_q;
  assign pass_idx    = pass_q;
  assign beat_idx    = beat_q;

endmodule

// File: tb/tb_psum_fifo_seq.sv
// Self-checking bench: drives the sequencer against a behavioural FIFO and
// compares drained rows with per-position sums over all passes.
module tb_psum_fifo_seq;

  localparam int AW = 3;
  localparam int FS = 8;
  localparam int PW = 4;

  logic            clk1 = 1'b0;
  logic            rd_clr, start, in_valid;
  logic [PW-1:0]   num_pass;
  logic [AW:0]     row_len;
  logic            busy, done, cfg_err;
  logic            fifo_wr_en, fifo_rd_en, fifo_wr_inc, fifo_rd_inc;
  logic            fifo_re_buffer, fifo_wr_clr, fifo_ptr_rd_clr, out_valid;
  logic [PW-1:0]   pass_idx;
  logic [AW:0]     beat_idx;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk1 = ~clk1;

  psum_fifo_seq #(.ADD_WIDTH(AW), .FIFO_SIZE(FS), .PASS_W(PW)) dut (
    .clk1(clk1), .rd_clr(rd_clr), .start(start), .num_pass(num_pass),
    .row_len(row_len), .in_valid(in_valid), .busy(busy), .done(done),
    .cfg_err(cfg_err), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .fifo_wr_inc(fifo_wr_inc), .fifo_rd_inc(fifo_rd_inc),
    .fifo_re_buffer(fifo_re_buffer), .fifo_wr_clr(fifo_wr_clr),
    .fifo_ptr_rd_clr(fifo_ptr_rd_clr), .out_valid(out_valid),
    .pass_idx(pass_idx), .beat_idx(beat_idx)
  );

  // Behavioural FIFO: one-cycle read latency, write controls registered once.
  logic [15:0] tbl [16][16];
  logic [15:0] mem [FS];
  logic [AW-1:0] wp, rp;
  logic [15:0] data_in, data_r, data_out;
  logic        wr_inc_r, re_buf_r;

  assign data_in = tbl[pass_idx][beat_idx];

  always @(posedge clk1 or posedge rd_clr) begin
    if (rd_clr) begin
      wp <= '0; rp <= '0; wr_inc_r <= 1'b0; re_buf_r <= 1'b0;
    end else begin
      wr_inc_r <= fifo_wr_inc;
      re_buf_r <= fifo_re_buffer;
      data_r   <= data_in;
      if (fifo_rd_en) data_out <= mem[rp];
      if (fifo_rd_inc) rp <= rp + 1'b1;
      if (wr_inc_r) begin
        mem[wp] <= re_buf_r ? data_r + data_out : data_r;
        wp <= wp + 1'b1;
      end
      if (fifo_wr_clr) wp <= '0;
      if (fifo_ptr_rd_clr) rp <= '0;
    end
  end

  // Activity monitor
  int cyc = 0, n_fill = 0, n_accw = 0, n_accr = 0, n_drain = 0, n_done = 0;
  int n_bad = 0, n_out = 0, last_ov = 0, done_cyc = 0;
  logic [15:0] drained [1024];

  always @(negedge clk1) begin
    cyc <= cyc + 1;
    if (out_valid) begin
      drained[n_out % 1024] <= data_out;
      n_out   <= n_out + 1;
      last_ov <= cyc;
    end
    if (fifo_wr_en && !fifo_re_buffer) n_fill <= n_fill + 1;
    if (fifo_wr_en && fifo_re_buffer)  n_accw <= n_accw + 1;
    if (fifo_rd_en && fifo_re_buffer)  n_accr <= n_accr + 1;
    if (fifo_rd_en && !fifo_re_buffer) n_drain <= n_drain + 1;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (((fifo_wr_en || (fifo_rd_en && fifo_re_buffer)) && !in_valid) ||
        ((fifo_rd_en && fifo_re_buffer) != (fifo_wr_en && fifo_re_buffer)) ||
        (fifo_wr_inc !== fifo_wr_en) || (fifo_rd_inc !== fifo_rd_en))
      n_bad <= n_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({busy, done, cfg_err, fifo_wr_en, fifo_rd_en, fifo_wr_inc, fifo_rd_inc,
                    fifo_re_buffer, fifo_wr_clr, fifo_ptr_rd_clr, out_valid, pass_idx, beat_idx}), 32'd0);
  endtask

  // dens < 0 selects the alternating 1010 in_valid pattern
  task automatic run_job(input int np, input int rl, input int dens, input bit k_data, input bit dbl);
    logic [15:0] expv [16];
    int b_fill, b_accw, b_accr, b_drain, b_done, b_bad, b_out;
    int cycles;
    bit seen;
    for (int p = 0; p < 16; p++)
      for (int k = 0; k < 16; k++)
        tbl[p][k] = k_data ? 16'(k + 1) : 16'($urandom_range(255));
    for (int k = 0; k < 16; k++) begin
      expv[k] = '0;
      for (int p = 0; p < np; p++) expv[k] = expv[k] + tbl[p][k];
    end
    b_fill = n_fill; b_accw = n_accw; b_accr = n_accr; b_drain = n_drain;
    b_done = n_done; b_bad = n_bad; b_out = n_out;
    cycles = 0; seen = 1'b0;
    @(posedge clk1); #1;
    num_pass = PW'(np); row_len = (AW+1)'(rl); start = 1'b1; in_valid = 1'b0;
    @(posedge clk1); #1;
    start = 1'b0;
    num_pass = PW'($urandom_range(1, 15)); row_len = (AW+1)'($urandom_range(1, 8));
    @(negedge clk1);
    check("busy_after_start", 32'(busy), 32'd1);
    while (!seen && cycles < 2000) begin
      @(posedge clk1); #1;
      in_valid = (dens < 0) ? ~cycles[0] : ($urandom_range(99) < dens);
      start = dbl && (cycles == 3 || cycles == 20);
      cycles++;
      @(negedge clk1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check($sformatf("done_seen np=%0d rl=%0d", np, rl), 32'(seen), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk1); #1; in_valid = 1'b0;
    repeat (3) @(negedge clk1);
    check("fill_beats", 32'(n_fill - b_fill), 32'(rl));
    check("acc_writes", 32'(n_accw - b_accw), 32'((np - 1) * rl));
    check("acc_reads", 32'(n_accr - b_accr), 32'((np - 1) * rl));
    check("drain_reads", 32'(n_drain - b_drain), 32'(rl));
    check("out_beats", 32'(n_out - b_out), 32'(rl));
    check("done_count", 32'(n_done - b_done), 32'd1);
    check("done_after_last", 32'(done_cyc - last_ov), 32'd1);
    check("enable_rules", 32'(n_bad - b_bad), 32'd0);
    for (int k = 0; k < rl; k++)
      check($sformatf("psum[%0d]", k), 32'(drained[(b_out + k) % 1024]), 32'(expv[k]));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic cfg_bad(input int np, input int rl);
    @(posedge clk1); #1;
    num_pass = PW'(np); row_len = (AW+1)'(rl); start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    @(negedge clk1);
    check($sformatf("cfg_err_pulse np=%0d rl=%0d", np, rl), 32'(cfg_err), 32'd1);
    check("cfg_busy", 32'(busy), 32'd0);
    @(negedge clk1);
    check("cfg_err_clear", 32'(cfg_err), 32'd0);
    check("cfg_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int waited;
    rd_clr = 1'b1; start = 1'b0; in_valid = 1'b0; num_pass = '0; row_len = '0;
    #2;
    check_all_zero("reset_outputs");
    repeat (2) @(posedge clk1);
    #1 rd_clr = 1'b0;

    run_job(1, 4, 100, 1'b1, 1'b0);
    run_job(3, 4, 100, 1'b1, 1'b0);
    run_job(3, 4, -1, 1'b1, 1'b0);
    run_job(1, 8, 100, 1'b0, 1'b0);
    run_job(2, 1, 60, 1'b0, 1'b0);

    cfg_bad(2, 0);
    cfg_bad(2, 9);
    cfg_bad(0, 4);

    // Asynchronous reset in the middle of an accumulate pass
    @(posedge clk1); #1;
    num_pass = 4'd3; row_len = 4'd4; start = 1'b1; in_valid = 1'b1;
    @(posedge clk1); #1 start = 1'b0;
    waited = 0;
    @(negedge clk1);
    while (!fifo_re_buffer && waited < 100) begin
      @(negedge clk1);
      waited++;
    end
    check("acc_reached", 32'(fifo_re_buffer & fifo_wr_en), 32'd1);
    #2 rd_clr = 1'b1;
    #1 check_all_zero("async_reset_mid_acc");
    @(posedge clk1); #1 rd_clr = 1'b0; in_valid = 1'b0;

    run_job(3, 4, 100, 1'b1, 1'b1);
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(1, 6), $urandom_range(1, 8), $urandom_range(30, 100),
              1'b0, 1'($urandom_range(1)));
    run_job(15, 8, 100, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
